// File: rtl/psinha_rvp_core.sv
// psinha_rvp_core -- 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with the
// custom 32-bit encoding.
//
// The pipeline adds operand forwarding, a load-use stall, branch flush,
// register-compare branches, HALT, run gating and an IMEM load port.
//
// Ports:
//   clk        rising-edge clock
//   RN         asynchronous active-high reset
//   run        pipeline advances only while 1
//   imem_we    IMEM write strobe, honoured only while run=0
//   imem_waddr IMEM write address
//   imem_wdata IMEM write data
//   NPC        current fetch PC
//   WB_OUT     last written-back value
//   WB_VALID   one-cycle pulse per committed register write
//   HALTED     sticky, set when HALT reaches WB
module psinha_rvp_core #(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64,
   parameter bit FWD_EN     = 1'b1
) (
   input  logic                          clk,
   input  logic                          RN,
   input  logic                          run,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [$clog2(IMEM_DEPTH)-1:0] NPC,
   output logic [XLEN-1:0]               WB_OUT,
   output logic                          WB_VALID,
   output logic                          HALTED
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [6:0]  OP_AR   = 7'd0;
   localparam logic [6:0]  OP_M    = 7'd1;
   localparam logic [6:0]  OP_BR   = 7'd2;
   localparam logic [6:0]  OP_SH   = 7'd3;
   localparam logic [6:0]  OP_HALT = 7'h7F;

   // ---------------- decode helpers (pure functions of an IR) ----------------
   function automatic logic wr_of(input logic [31:0] ir);
      case (ir[6:0])
         OP_AR:   wr_of = (ir[31:25] == 7'd1) ? (ir[14:12] <= 3'd5) : (ir[14:12] <= 3'd4);
         OP_M:    wr_of = (ir[14:12] == 3'd0);
         OP_SH:   wr_of = (ir[14:12] <= 3'd1);
         default: wr_of = 1'b0;
      endcase
   endfunction

   function automatic logic is_lw(input logic [31:0] ir);
      return (ir[6:0] == OP_M) && (ir[14:12] == 3'd0);
   endfunction

   function automatic logic is_sw(input logic [31:0] ir);
      return (ir[6:0] == OP_M) && (ir[14:12] == 3'd1);
   endfunction

   function automatic logic is_br(input logic [31:0] ir);
      return (ir[6:0] == OP_BR) && (ir[14:12] <= 3'd1);
   endfunction

   // True when register r (nonzero) is actually read by instruction ir.
   function automatic logic src_hit(input logic [31:0] ir, input logic [4:0] r);
      logic use1, use2, use_rd;
      use1   = wr_of(ir) || is_sw(ir) || is_br(ir);
      use2   = ((ir[6:0] == OP_AR) && (ir[31:25] == 7'd1) && (ir[14:12] <= 3'd5)) ||
               ((ir[6:0] == OP_SH) && (ir[14:12] <= 3'd1));
      use_rd = is_sw(ir) || is_br(ir);
      return (r != 5'd0) && ((use1 && ir[19:15] == r) || (use2 && ir[24:20] == r) ||
                             (use_rd && ir[11:7] == r));
   endfunction

   // ---------------- state ----------------
   logic [31:0]     imem_mem [IMEM_DEPTH];
   logic [XLEN-1:0] regs_q [32], regs_d [32];
   logic [XLEN-1:0] dmem_q [DMEM_DEPTH], dmem_d [DMEM_DEPTH];
   logic [IAW-1:0]  pc_q, pc_d, ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
   logic [31:0]     ifid_ir_q, ifid_ir_d, idex_ir_q, idex_ir_d;
   logic [XLEN-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_c_q, idex_c_d;
   logic            exmem_wr_q, exmem_wr_d, exmem_lw_q, exmem_lw_d, exmem_sw_q, exmem_sw_d;
   logic            exmem_halt_q, exmem_halt_d;
   logic [4:0]      exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
   logic [XLEN-1:0] exmem_alu_q, exmem_alu_d, exmem_st_q, exmem_st_d;
   logic            memwb_wr_q, memwb_wr_d, memwb_halt_q, memwb_halt_d;
   logic [XLEN-1:0] memwb_res_q, memwb_res_d, wb_out_q, wb_out_d;
   logic            wb_valid_q, wb_valid_d, halted_q, halted_d;

   always_ff @(posedge clk) begin
      if (imem_we && !run) imem_mem[imem_waddr] <= imem_wdata;
   end

   // ---------------- ID: register read with write-first bypass from WB ----------------
   logic [4:0]      id_idx [3];
   logic [XLEN-1:0] id_val [3];
   assign id_idx[0] = ifid_ir_q[19:15];
   assign id_idx[1] = ifid_ir_q[24:20];
   assign id_idx[2] = ifid_ir_q[11:7];

   // ---------------- EX: operand forwarding ----------------
   logic [4:0]      ex_idx [3];
   logic [XLEN-1:0] ex_cap [3], ex_opnd [3];
   assign ex_idx[0] = idex_ir_q[19:15];
   assign ex_idx[1] = idex_ir_q[24:20];
   assign ex_idx[2] = idex_ir_q[11:7];
   assign ex_cap[0] = idex_a_q;
   assign ex_cap[1] = idex_b_q;
   assign ex_cap[2] = idex_c_q;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_opnd
         assign id_val[gi] = (id_idx[gi] == 5'd0) ? '0 :
                             (memwb_wr_q && memwb_rd_q == id_idx[gi]) ? memwb_res_q :
                             regs_q[id_idx[gi]];
         // Youngest producer wins: EX/MEM before MEM/WB before the ID capture.
         assign ex_opnd[gi] =
            (FWD_EN && exmem_wr_q && exmem_rd_q != 5'd0 && exmem_rd_q == ex_idx[gi]) ? exmem_alu_q :
            (FWD_EN && memwb_wr_q && memwb_rd_q != 5'd0 && memwb_rd_q == ex_idx[gi]) ? memwb_res_q :
            ex_cap[gi];
      end
   endgenerate

   logic [XLEN-1:0] ex_imm, ex_opb, ex_alu;
   logic            ex_taken;
   logic [IAW-1:0]  br_target;
   logic [2:0]      ex_f3;
   assign ex_f3     = idex_ir_q[14:12];
   assign ex_imm    = {{(XLEN-12){idex_ir_q[31]}}, idex_ir_q[31:20]};
   assign br_target = idex_pc_q + IAW'(1) + ex_imm[IAW-1:0];

   always_comb begin
      ex_alu   = '0;
      ex_taken = 1'b0;
      ex_opb   = (idex_ir_q[31:25] == 7'd1) ? ex_opnd[1] : ex_imm;
      case (idex_ir_q[6:0])
         OP_AR: begin
            case (ex_f3)
               3'd0:    ex_alu = ex_opnd[0] + ex_opb;
               3'd1:    ex_alu = ex_opnd[0] - ex_opb;
               3'd2:    ex_alu = ex_opnd[0] & ex_opb;
               3'd3:    ex_alu = ex_opnd[0] | ex_opb;
               3'd4:    ex_alu = ex_opnd[0] ^ ex_opb;
               3'd5:    ex_alu = {{(XLEN-1){1'b0}}, ($signed(ex_opnd[0]) < $signed(ex_opb))};
               default: ex_alu = '0;
            endcase
         end
         OP_M:  ex_alu = ex_opnd[0] + ex_imm;
         OP_BR: ex_taken = ((ex_f3 == 3'd0) && (ex_opnd[0] == ex_opnd[2])) ||
                           ((ex_f3 == 3'd1) && (ex_opnd[0] != ex_opnd[2]));
         OP_SH: ex_alu = (ex_f3 == 3'd0) ? (ex_opnd[0] << ex_opnd[1][4:0]) :
                                           (ex_opnd[0] >> ex_opnd[1][4:0]);
         default: ex_alu = '0;
      endcase
   end

   // ---------------- hazards ----------------
   logic load_use, nf_pend, stall, adv;
   assign load_use = is_lw(idex_ir_q) && src_hit(ifid_ir_q, idex_ir_q[11:7]);
   // Without forwarding, ID waits until no stage still owes a write to one of its sources.
   assign nf_pend  = (wr_of(idex_ir_q) && src_hit(ifid_ir_q, idex_ir_q[11:7])) ||
                     (exmem_wr_q && src_hit(ifid_ir_q, exmem_rd_q)) ||
                     (memwb_wr_q && src_hit(ifid_ir_q, memwb_rd_q));
   assign stall    = FWD_EN ? load_use : nf_pend;
   // A HALT sitting in WB freezes everything on the edge it is retired.
   assign adv      = run && !halted_q && !memwb_halt_q;

   // ---------------- next state ----------------
   always_comb begin
      regs_d = regs_q;            dmem_d = dmem_q;
      pc_d = pc_q;                ifid_pc_d = ifid_pc_q;   idex_pc_d = idex_pc_q;
      ifid_ir_d = ifid_ir_q;      idex_ir_d = idex_ir_q;
      idex_a_d = idex_a_q;        idex_b_d = idex_b_q;     idex_c_d = idex_c_q;
      exmem_wr_d = exmem_wr_q;    exmem_lw_d = exmem_lw_q; exmem_sw_d = exmem_sw_q;
      exmem_halt_d = exmem_halt_q; exmem_rd_d = exmem_rd_q;
      exmem_alu_d = exmem_alu_q;  exmem_st_d = exmem_st_q;
      memwb_wr_d = memwb_wr_q;    memwb_rd_d = memwb_rd_q;
      memwb_halt_d = memwb_halt_q; memwb_res_d = memwb_res_q;
      wb_out_d = wb_out_q;
      wb_valid_d = 1'b0;
      halted_d = halted_q || (run && memwb_halt_q);
      if (adv) begin
         if (memwb_wr_q) begin
            if (memwb_rd_q != 5'd0) regs_d[memwb_rd_q] = memwb_res_q;
            wb_out_d   = memwb_res_q;
            wb_valid_d = 1'b1;
         end
         if (exmem_sw_q) dmem_d[exmem_alu_q[DAW-1:0]] = exmem_st_q;
         memwb_wr_d   = exmem_wr_q;
         memwb_rd_d   = exmem_rd_q;
         memwb_halt_d = exmem_halt_q;
         memwb_res_d  = exmem_lw_q ? dmem_q[exmem_alu_q[DAW-1:0]] : exmem_alu_q;
         exmem_wr_d   = wr_of(idex_ir_q);
         exmem_lw_d   = is_lw(idex_ir_q);
         exmem_sw_d   = is_sw(idex_ir_q);
         exmem_halt_d = (idex_ir_q[6:0] == OP_HALT);
         exmem_rd_d   = idex_ir_q[11:7];
         exmem_alu_d  = ex_alu;
         exmem_st_d   = ex_opnd[2];
         if (ex_taken) begin
            pc_d      = br_target;
            ifid_ir_d = NOP;
            idex_ir_d = NOP;
         end else if (stall) begin
            idex_ir_d = NOP;
         end else begin
            pc_d      = pc_q + IAW'(1);
            ifid_ir_d = imem_mem[pc_q];
            ifid_pc_d = pc_q;
            idex_ir_d = ifid_ir_q;
            idex_pc_d = ifid_pc_q;
            idex_a_d  = id_val[0];
            idex_b_d  = id_val[1];
            idex_c_d  = id_val[2];
         end
      end
   end

   always_ff @(posedge clk or posedge RN) begin
      if (RN) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= XLEN'(i);
         for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
         pc_q <= '0;         ifid_pc_q <= '0;      idex_pc_q <= '0;
         ifid_ir_q <= NOP;   idex_ir_q <= NOP;
         idex_a_q <= '0;     idex_b_q <= '0;       idex_c_q <= '0;
         exmem_wr_q <= 1'b0; exmem_lw_q <= 1'b0;   exmem_sw_q <= 1'b0;
         exmem_halt_q <= 1'b0; exmem_rd_q <= '0;
         exmem_alu_q <= '0;  exmem_st_q <= '0;
         memwb_wr_q <= 1'b0; memwb_rd_q <= '0;     memwb_halt_q <= 1'b0;
         memwb_res_q <= '0;  wb_out_q <= '0;       wb_valid_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         regs_q <= regs_d;   dmem_q <= dmem_d;
         pc_q <= pc_d;       ifid_pc_q <= ifid_pc_d; idex_pc_q <= idex_pc_d;
         ifid_ir_q <= ifid_ir_d; idex_ir_q <= idex_ir_d;
         idex_a_q <= idex_a_d; idex_b_q <= idex_b_d; idex_c_q <= idex_c_d;
         exmem_wr_q <= exmem_wr_d; exmem_lw_q <= exmem_lw_d; exmem_sw_q <= exmem_sw_d;
         exmem_halt_q <= exmem_halt_d; exmem_rd_q <= exmem_rd_d;
         exmem_alu_q <= exmem_alu_d; exmem_st_q <= exmem_st_d;
         memwb_wr_q <= memwb_wr_d; memwb_rd_q <= memwb_rd_d; memwb_halt_q <= memwb_halt_d;
         memwb_res_q <= memwb_res_d; wb_out_q <= wb_out_d; wb_valid_q <= wb_valid_d;
         halted_q <= halted_d;
      end
   end

   assign NPC      = pc_q;
   assign WB_OUT   = wb_out_q;
   assign WB_VALID = wb_valid_q;
   assign HALTED   = halted_q;
endmodule

// File: tb/tb_psinha_rvp_core.sv
// Scoreboard bench for psinha_rvp_core: two instances (forwarding on / off) run
// the same directed programs; expected WB values are queued at launch and a
// negedge monitor pops them whenever WB_VALID is seen.
module tb_psinha_rvp_core;
   localparam int XLEN = 32;
   localparam int IMEM_DEPTH = 64;
   localparam int DMEM_DEPTH = 64;
   localparam int IAW = 6;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'h0000_007F;

   logic clk = 1'b0;
   logic RN, run, imem_we;
   logic [IAW-1:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic [IAW-1:0] npc_f, npc_n;
   logic [XLEN-1:0] wb_out_f, wb_out_n;
   logic wb_valid_f, wb_valid_n, halted_f, halted_n;

   always #5 clk = ~clk;

   psinha_rvp_core #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .FWD_EN(1'b1)) dut (
      .clk(clk), .RN(RN), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .NPC(npc_f), .WB_OUT(wb_out_f), .WB_VALID(wb_valid_f), .HALTED(halted_f));

   psinha_rvp_core #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .RN(RN), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .NPC(npc_n), .WB_OUT(wb_out_n), .WB_VALID(wb_valid_n), .HALTED(halted_n));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int k0 = 0;
   logic [XLEN-1:0] exp_f[$], exp_n[$];
   int wbc_f[$], wbc_n[$];
   logic [XLEN-1:0] e_f, e_n;
   logic [31:0] prog[$];
   logic [XLEN-1:0] expq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!RN && wb_valid_f) begin
         wbc_f.push_back(cyc);
         $display("wb fwd   cyc=%0d out=%0h", cyc, wb_out_f);
         if (exp_f.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_extra_fwd: got WB_OUT=%0h required no commit", wb_out_f);
         end else begin
            e_f = exp_f.pop_front();
            check("wb_out_fwd", wb_out_f, e_f);
         end
      end
      if (!RN && wb_valid_n) begin
         wbc_n.push_back(cyc);
         $display("wb nofwd cyc=%0d out=%0h", cyc, wb_out_n);
         if (exp_n.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_extra_nofwd: got WB_OUT=%0h required no commit", wb_out_n);
         end else begin
            e_n = exp_n.pop_front();
            check("wb_out_nofwd", wb_out_n, e_n);
         end
      end
   end

   function automatic logic [31:0] r_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd1, rs2, rs1, f3, rd, 7'd0};
   endfunction
   function automatic logic [31:0] i_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, f3, rd, 7'd0};
   endfunction
   function automatic logic [31:0] sh_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, f3, rd, 7'd3};
   endfunction
   function automatic logic [31:0] m_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, f3, rd, 7'd1};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_prog();
      run = 1'b0;
      for (int a = 0; a < IMEM_DEPTH; a++) begin
         imem_we = 1'b1;
         imem_waddr = IAW'(a);
         imem_wdata = (a < prog.size()) ? prog[a] : NOP;
         tick();
      end
      imem_we = 1'b0;
   endtask

   task automatic do_reset();
      RN = 1'b1; run = 1'b0;
      tick(2);
      RN = 1'b0;
      tick();
   endtask

   task automatic start();
      exp_f = expq; exp_n = expq;
      wbc_f.delete(); wbc_n.delete();
      k0 = cyc;
      run = 1'b1;
   endtask

   task automatic wait_halt(input string name, input int limit);
      int n = 0;
      while (!(halted_f && halted_n) && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (!(halted_f && halted_n)) begin
         failures++;
         $display("FAIL %s_halt: got halted fwd=%0b nofwd=%0b required 1/1", name, halted_f, halted_n);
      end
      tick(2);
      check({name, "_drain_fwd"}, 64'(exp_f.size()), 64'd0);
      check({name, "_drain_nofwd"}, 64'(exp_n.size()), 64'd0);
      run = 1'b0;
   endtask

   task automatic build_p3();
      prog.delete();
      prog.push_back(32'h0020_9181);   // sw r3,r1,2
      prog.push_back(32'h0020_8681);   // lw r13,r1,2
      prog.push_back(32'h02d6_8700);   // add r14,r13,r13
      prog.push_back(HALT);
      expq.delete(); expq.push_back(32'd3); expq.push_back(32'd6);
   endtask

   task automatic build_alu();
      prog.delete(); expq.delete();
      prog.push_back(i_op(3'd0, 5'd20, 5'd5, 12'hFFF));   expq.push_back(32'd4);
      prog.push_back(r_op(3'd1, 5'd21, 5'd2, 5'd5));      expq.push_back(32'hFFFF_FFFD);
      prog.push_back(r_op(3'd5, 5'd22, 5'd21, 5'd1));     expq.push_back(32'd1);
      prog.push_back(r_op(3'd2, 5'd23, 5'd21, 5'd3));     expq.push_back(32'd1);
      prog.push_back(r_op(3'd3, 5'd24, 5'd4, 5'd3));      expq.push_back(32'd7);
      prog.push_back(r_op(3'd4, 5'd25, 5'd7, 5'd2));      expq.push_back(32'd5);
      prog.push_back(sh_op(3'd0, 5'd26, 5'd3, 5'd4));     expq.push_back(32'd48);
      prog.push_back(sh_op(3'd1, 5'd27, 5'd21, 5'd2));    expq.push_back(32'h3FFF_FFFF);
      prog.push_back(i_op(3'd4, 5'd28, 5'd9, 12'd15));    expq.push_back(32'd6);
      prog.push_back(i_op(3'd2, 5'd29, 5'd13, 12'd7));    expq.push_back(32'd5);
      prog.push_back(i_op(3'd3, 5'd30, 5'd16, 12'd1));    expq.push_back(32'd17);
      prog.push_back(i_op(3'd1, 5'd31, 5'd10, 12'd3));    expq.push_back(32'd7);
      prog.push_back(i_op(3'd0, 5'd0, 5'd1, 12'd5));      expq.push_back(32'd6);
      prog.push_back(r_op(3'd0, 5'd19, 5'd0, 5'd1));      expq.push_back(32'd1);
      prog.push_back(m_op(3'd1, 5'd30, 5'd0, 12'd60));
      prog.push_back(m_op(3'd0, 5'd18, 5'd31, 12'd53));   expq.push_back(32'd17);
      prog.push_back(r_op(3'd6, 5'd17, 5'd1, 5'd2));
      prog.push_back(HALT);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IAW-1:0] npc_hold;
      int n;
      RN = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      tick(2);

      // Reset state
      check("rst_npc", 64'(npc_f), 64'd0);
      check("rst_wb_out", 64'(wb_out_f), 64'd0);
      check("rst_wb_valid", 64'(wb_valid_f), 64'd0);
      check("rst_halted", 64'(halted_f), 64'd0);
      check("rst_reg5", 64'(dut.regs_q[5]), 64'd5);
      check("rst_dm3", 64'(dut.dmem_q[3]), 64'd0);

      // T1: single add then HALT
      prog.delete(); prog.push_back(32'h0220_8300); prog.push_back(HALT);
      expq.delete(); expq.push_back(32'd3);
      load_prog(); do_reset(); start();
      wait_halt("t1", 40);
      check("t1_latency_fwd", 64'(wbc_f[0] - k0), 64'd5);
      check("t1_latency_nofwd", 64'(wbc_n[0] - k0), 64'd5);
      check("t1_reg6", 64'(dut.regs_q[6]), 64'd3);
      check("t1_halted", 64'(halted_f), 64'd1);

      // T2: back-to-back dependency
      prog.delete(); prog.push_back(32'h0220_8300); prog.push_back(32'h0263_0380); prog.push_back(HALT);
      expq.delete(); expq.push_back(32'd3); expq.push_back(32'd6);
      load_prog(); do_reset(); start();
      wait_halt("t2", 40);
      check("t2_second_fwd", 64'(wbc_f[1] - k0), 64'd6);
      check("t2_second_nofwd", 64'(wbc_n[1] - k0), 64'd9);
      check("t2_reg7_fwd", 64'(dut.regs_q[7]), 64'd6);
      check("t2_reg7_nofwd", 64'(dut_nf.regs_q[7]), 64'd6);

      // T3: store, load, load-use
      build_p3(); load_prog(); do_reset(); start();
      wait_halt("t3", 40);
      check("t3_lw_fwd", 64'(wbc_f[0] - k0), 64'd6);
      check("t3_use_fwd", 64'(wbc_f[1] - k0), 64'd8);
      check("t3_use_nofwd", 64'(wbc_n[1] - k0), 64'd10);
      check("t3_dm3", 64'(dut.dmem_q[3]), 64'd3);
      check("t3_reg13", 64'(dut.regs_q[13]), 64'd3);
      check("t3_reg14", 64'(dut.regs_q[14]), 64'd6);

      // T4: taken beq at 9 -> 25
      prog.delete();
      for (int i = 0; i < 9; i++) prog.push_back(NOP);
      prog.push_back(32'h00f0_0002);
      prog.push_back(r_op(3'd0, 5'd8, 5'd1, 5'd2));
      prog.push_back(r_op(3'd0, 5'd9, 5'd1, 5'd1));
      while (prog.size() < 25) prog.push_back(NOP);
      prog.push_back(r_op(3'd0, 5'd14, 5'd2, 5'd2));
      prog.push_back(HALT);
      expq.delete(); expq.push_back(32'd4);
      load_prog(); do_reset(); start();
      n = 0;
      while (npc_f != IAW'(9) && n < 50) begin tick(); n++; end
      check("t4_reach9", 64'(npc_f), 64'd9);
      tick(3);
      check("t4_npc25", 64'(npc_f), 64'd25);
      wait_halt("t4", 60);
      check("t4_reg8", 64'(dut.regs_q[8]), 64'd8);
      check("t4_reg9", 64'(dut.regs_q[9]), 64'd9);
      check("t4_reg14", 64'(dut.regs_q[14]), 64'd4);

      // T5: not-taken bne
      prog.delete(); prog.push_back(32'h00f0_1002); prog.push_back(32'h0220_8300); prog.push_back(HALT);
      expq.delete(); expq.push_back(32'd3);
      load_prog(); do_reset(); start();
      wait_halt("t5", 40);
      check("t5_latency_fwd", 64'(wbc_f[0] - k0), 64'd6);
      check("t5_latency_nofwd", 64'(wbc_n[0] - k0), 64'd6);

      // T6: ALU coverage
      build_alu(); load_prog(); do_reset(); start();
      wait_halt("t6", 100);
      check("t6_reg0", 64'(dut.regs_q[0]), 64'd0);
      check("t6_reg17", 64'(dut.regs_q[17]), 64'd17);
      check("t6_dm60", 64'(dut.dmem_q[60]), 64'd17);
      check("t6_reg27_nofwd", 64'(dut_nf.regs_q[27]), 64'h3FFF_FFFF);

      // T7: reset mid-run, then clean rerun
      build_p3(); load_prog(); do_reset();
      expq.delete(); start();
      tick(4);
      check("t7_dm3_before", 64'(dut.dmem_q[3]), 64'd3);
      RN = 1'b1; run = 1'b0;
      #2;
      check("t7_npc", 64'(npc_f), 64'd0);
      check("t7_wb_valid", 64'(wb_valid_f), 64'd0);
      check("t7_dm3", 64'(dut.dmem_q[3]), 64'd0);
      check("t7_reg13", 64'(dut.regs_q[13]), 64'd13);
      tick(); RN = 1'b0; tick();
      build_p3(); start();
      wait_halt("t7", 40);
      check("t7_use_fwd", 64'(wbc_f[1] - k0), 64'd8);
      check("t7_reg14", 64'(dut.regs_q[14]), 64'd6);
      check("t7_dm3_after", 64'(dut.dmem_q[3]), 64'd3);

      // T8: run dropped for 3 cycles mid-program
      build_alu(); load_prog(); do_reset(); start();
      tick(7);
      run = 1'b0;
      npc_hold = npc_f;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t8_npc_frozen", 64'(npc_f), 64'(npc_hold));
         check("t8_wb_valid", 64'(wb_valid_f), 64'd0);
      end
      run = 1'b1;
      wait_halt("t8", 100);
      check("t8_reg22", 64'(dut.regs_q[22]), 64'd1);
      check("t8_reg31", 64'(dut.regs_q[31]), 64'd7);
      check("t8_reg18", 64'(dut.regs_q[18]), 64'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
